// File: rtl/display_scroll_controller.sv
// Scroll-window FSM for a 4-digit multiplexed display, plus the free-running
// digit scan that drives digitSel and the active-low anode enables.
module display_scroll_controller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       productValid,
    input  logic       clearReq,
    input  logic       scrollLeft,
    input  logic       scrollRight,
    output logic [1:0] displayControlSignal,
    output logic [1:0] digitSel,
    output logic [3:0] anodes,
    output logic       atLeftLimit,
    output logic       atRightLimit
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_START  = 2'b00,
        ST_RIGHT  = 2'b01,
        ST_MIDDLE = 2'b10,
        ST_LEFT   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          sl_q, sr_q, pv_q;
    logic          ev_left, ev_right, ev_valid;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dsel_q, dsel_d;
    logic [3:0]    an_q, an_d;

    assign ev_left  = scrollLeft   & ~sl_q;
    assign ev_right = scrollRight  & ~sr_q;
    assign ev_valid = productValid & ~pv_q;

    // Priority: clearReq, then loss of productValid, then scroll/valid events.
    always_comb begin
        state_d = state_q;
        if (clearReq) begin
            state_d = ST_START;
        end else if (state_q != ST_START && !productValid) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_START: begin
                    if (ev_valid) state_d = ST_RIGHT;
                end
                ST_RIGHT: begin
                    if (ev_left && !ev_right) state_d = ST_MIDDLE;
                end
                ST_MIDDLE: begin
                    if (ev_left && !ev_right)      state_d = ST_LEFT;
                    else if (ev_right && !ev_left) state_d = ST_RIGHT;
                end
                ST_LEFT: begin
                    if (ev_right && !ev_left) state_d = ST_MIDDLE;
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        dsel_d = dsel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            dsel_d = dsel_q + 2'd1;
        end
        case (dsel_d)
            2'd0:    an_d = 4'b1110;
            2'd1:    an_d = 4'b1101;
            2'd2:    an_d = 4'b1011;
            default: an_d = 4'b0111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
            dsel_q  <= 2'd0;
            an_q    <= 4'b1110;
        end else begin
            state_q <= state_d;
            sl_q    <= scrollLeft;
            sr_q    <= scrollRight;
            pv_q    <= productValid;
            cnt_q   <= cnt_d;
            dsel_q  <= dsel_d;
            an_q    <= an_d;
        end
    end

    assign displayControlSignal = state_q;
    assign digitSel             = dsel_q;
    assign anodes               = an_q;
    assign atLeftLimit          = (state_q == ST_LEFT);
    assign atRightLimit         = (state_q == ST_RIGHT);

endmodule

// File: tb/tb_display_scroll_controller.sv
// Directed bench: expected window codes are queued as each step is driven and
// checked after the edge; the digit scan is checked every cycle from a cycle count.
module tb_display_scroll_controller;

    logic       clk = 1'b0;
    logic       rst, productValid, clearReq, scrollLeft, scrollRight;
    logic [1:0] displayControlSignal, digitSel;
    logic [3:0] anodes;
    logic       atLeftLimit, atRightLimit;

    typedef struct {
        string      tag;
        logic [1:0] dcs;
    } exp_t;

    exp_t        sb[$];
    int unsigned nchk  = 0;
    int unsigned npass = 0;
    int unsigned ncyc  = 0;
    logic [3:0]  an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    display_scroll_controller #(.REFRESH_DIV(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .productValid        (productValid),
        .clearReq            (clearReq),
        .scrollLeft          (scrollLeft),
        .scrollRight         (scrollRight),
        .displayControlSignal(displayControlSignal),
        .digitSel            (digitSel),
        .anodes              (anodes),
        .atLeftLimit         (atLeftLimit),
        .atRightLimit        (atRightLimit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Queue the expected window, clock once, then pop and compare all outputs.
    task automatic tick(input logic [1:0] exp_dcs, input string tag);
        exp_t       e;
        logic [1:0] exp_sel;
        e.tag = tag;
        e.dcs = exp_dcs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) ncyc = 0;
        else     ncyc++;
        e = sb.pop_front();
        exp_sel = 2'((ncyc / 4) % 4);
        chk({e.tag, ".dcs"},   {2'b00, displayControlSignal}, {2'b00, e.dcs});
        chk({e.tag, ".left"},  {3'b000, atLeftLimit},  {3'b000, e.dcs == 2'b11});
        chk({e.tag, ".right"}, {3'b000, atRightLimit}, {3'b000, e.dcs == 2'b01});
        chk({e.tag, ".dsel"},  {2'b00, digitSel}, {2'b00, exp_sel});
        chk({e.tag, ".anodes"}, anodes, an_tab[exp_sel]);
        chk({e.tag, ".onehot"}, 4'($countones(~anodes)), 4'd1);
    endtask

    initial begin
        rst = 1'b1; productValid = 1'b0; clearReq = 1'b0;
        scrollLeft = 1'b0; scrollRight = 1'b0;

        tick(2'b00, "reset0");
        tick(2'b00, "reset1");
        rst = 1'b0;
        tick(2'b00, "idle");

        productValid = 1'b1;
        tick(2'b01, "pv_event");

        scrollLeft = 1'b1; tick(2'b10, "sl1");
        scrollLeft = 1'b0; tick(2'b10, "sl1_rel");
        scrollLeft = 1'b1; tick(2'b11, "sl2");
        scrollLeft = 1'b0; tick(2'b11, "sl2_rel");
        scrollLeft = 1'b1; tick(2'b11, "sl3_sat");
        scrollLeft = 1'b0; tick(2'b11, "sl3_rel");

        scrollRight = 1'b1; tick(2'b10, "sr_left");
        scrollRight = 1'b0; tick(2'b10, "sr_left_rel");
        scrollRight = 1'b1; tick(2'b01, "sr_mid");
        scrollRight = 1'b0; tick(2'b01, "sr_mid_rel");
        scrollRight = 1'b1; tick(2'b01, "sr_sat");
        scrollRight = 1'b0; tick(2'b01, "sr_sat_rel");

        scrollLeft = 1'b1;
        tick(2'b10, "hold_first");
        for (int i = 1; i < 50; i++) tick(2'b10, "hold");
        scrollLeft = 1'b0; tick(2'b10, "hold_rel");

        scrollLeft = 1'b1; scrollRight = 1'b1; tick(2'b10, "both");
        scrollLeft = 1'b0; scrollRight = 1'b0; tick(2'b10, "both_rel");
        scrollRight = 1'b1; tick(2'b01, "sr_only");
        scrollRight = 1'b0; tick(2'b01, "sr_only_rel");

        scrollLeft = 1'b1; tick(2'b10, "to_mid");
        scrollLeft = 1'b0; tick(2'b10, "to_mid_rel");
        scrollLeft = 1'b1; tick(2'b11, "to_left");
        scrollLeft = 1'b0; tick(2'b11, "to_left_rel");
        clearReq = 1'b1; scrollRight = 1'b1; tick(2'b00, "clear_ovr");
        clearReq = 1'b0; scrollRight = 1'b0; tick(2'b00, "clear_rel");

        productValid = 1'b0; tick(2'b00, "pv_low");
        productValid = 1'b1; tick(2'b01, "pv_again");
        scrollLeft = 1'b1; tick(2'b10, "mid2");
        scrollLeft = 1'b0; tick(2'b10, "mid2_rel");
        productValid = 1'b0; tick(2'b00, "pv_fall");

        productValid = 1'b1; tick(2'b01, "pv3");
        scrollLeft = 1'b1; tick(2'b10, "m3");
        scrollLeft = 1'b0; tick(2'b10, "m3_rel");
        scrollLeft = 1'b1; tick(2'b11, "l3");
        scrollLeft = 1'b0; tick(2'b11, "l3_rel");
        for (int i = 0; i < 16 && ((ncyc + 1) / 4) % 4 != 2; i++) tick(2'b11, "wait_dsel2");
        tick(2'b11, "at_dsel2");
        chk("dsel_is_2", {2'b00, digitSel}, 4'd2);

        rst = 1'b1; scrollLeft = 1'b1; clearReq = 1'b1;
        tick(2'b00, "mid_rst");
        rst = 1'b0; clearReq = 1'b0; scrollLeft = 1'b0;
        tick(2'b01, "post_rst_pv");
        for (int i = 0; i < 20; i++) tick(2'b01, "scan");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
